seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds eight hex digits, a per-digit enable mask and a per-digit decimal-point mask written by the CPU side. It sequences the digits one slot at a time, inserting anti-ghosting blanking, and drives the active-low anode, segment and dp pins. Writes land in shadow registers and are committed only at frame boundaries, so the display never shows a half-updated value.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot (1 ms at 50 MHz); legal range ≥ 4.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYC < SCAN_DIV.
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write strobe, one cycle per write.
- wr_sel  in  2  write target: 0 = digit data, 1 = masks, 2/3 = reserved (write ignored).
- wr_data  in  32  sel 0: nibble i (bits 4i+3:4i) → digit i. sel 1: [7:0] enable mask, [15:8] dp mask, rest ignored.
- pending  out  1  shadow holds uncommitted data.
- frame_done  out  1  one-cycle pulse on each frame commit point.
- an  out  8  anode enables, active-low; an[i] = digit i.
- seg  out  7  segments a..g = seg[0]..seg[6], active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Registers:
  - Shadow and active copies of: data[31:0], en_mask[7:0], dp_mask[7:0].
  - Slot prescaler psc, 0..SCAN_DIV-1.
  - Digit index dig[2:0].
- Reset values:
  - All six copies reset to data = 0, en_mask = 8'hFF, dp_mask = 8'h00.
  - psc = 0, dig = 0, pending = 0, frame_done = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1.
- Write:
  - When wr_en is high and wr_sel is 0 or 1, update the selected shadow field and set pending.
  - wr_sel 2/3: no state change.
- Slot sequencing:
  - psc increments every cycle and wraps from SCAN_DIV-1 to 0.
  - On the wrap, dig increments mod 8.
  - A frame is 8*SCAN_DIV cycles: digit 0 through digit 7.
- Slot phases, a two-state FSM derived from psc:
  - BLANK while psc < BLANK_CYC.
  - DRIVE otherwise.
- Output computation, registered:
  - In BLANK, or in DRIVE with active en_mask[dig] = 0: an = 8'hFF, seg = 7'h7F, dp = 1.
  - In DRIVE with en_mask[dig] = 1: an = ~(1 << dig), seg = hex7(active nibble dig), dp = ~dp_mask[dig].
  - Disabled digits keep their time slot, so the refresh rate and brightness are independent of the mask.
- Hex decode (seg[6:0], active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Commit point: the cycle with dig = 7 and psc = SCAN_DIV-1.
  - frame_done = 1 in the following cycle.
  - If pending = 1: all three active fields ← shadow, and pending clears.
  - If pending = 0: active fields unchanged.
- Simultaneous write and commit in the same cycle:
  - The commit copies the pre-write shadow.
  - The new write updates the shadow.
  - pending stays 1.
  - The new value commits at the next frame.
- Reset mid-frame: everything returns to reset values on the next edge. Uncommitted shadow data is discarded.

## Timing
- Cycle 0 is the first cycle with rst low. psc = 0 and dig = 0 in cycle 0.
- Outputs are registered: the pins reflect the psc/dig state of the previous cycle (one-cycle latency).
- an[0] first goes low in cycle BLANK_CYC+1, provided en_mask[0] = 1.
- Digit i drives during cycles i*SCAN_DIV+BLANK_CYC+1 .. (i+1)*SCAN_DIV of each frame.
- frame_done pulses in cycle 8*SCAN_DIV·k for k ≥ 1, i.e. the first cycle of each new frame.
- New active values are visible on the pins from the first DRIVE cycle of digit 0 after the commit.
- Worst-case latency from a write to display: one frame plus BLANK_CYC+1 cycles.
- At any time, at most one an bit is low.

## Test plan
All scenarios use SCAN_DIV = 8 and BLANK_CYC = 2.

- **Reset/default:** release rst.
  - an = FF for cycles 0–2.
  - an = FE and seg = 1000000 for cycles 3–8.
  - an = FD from cycle 11.
  - frame_done high only in cycle 64.
- **Hex data:** write sel 0 = 32'hFEDC_BA98 at cycle 5.
  - pending = 1 from cycle 6 until the commit.
  - From cycle 67: digit 0 shows 0000000 ("8") and digit 7 shows 0001110 ("F").
- **Masks:** write sel 1 = 32'h0000_8055.
  - Next frame: only digits 0, 2, 4, 6 light.
  - Odd slots stay an = FF for the full 8 cycles.
  - Digit 7 is disabled, so its dp never asserts.
  - Frame period is still 64 cycles.
- **Write on commit cycle:** write sel 0 = 32'h1111_1111 exactly at cycle 63.
  - frame_done in cycle 64, pending still 1.
  - Display keeps the old data for frame 1.
  - "1" (1111001) appears from cycle 131; pending clears after cycle 127.
- **Reset mid-frame:** write data, then assert rst at cycle 30 for 1 cycle.
  - Next cycle: an = FF, pending = 0, psc = 0, dig = 0.
  - Display shows zeros again.
  - Shadow write lost: no commit at the next frame boundary.
- **Reserved select:** wr_sel = 2 with wr_data = 32'hFFFF_FFFF.
  - pending stays 0.
  - Display and frame_done cadence unchanged.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display.
//
// The CPU side writes digit data and masks into shadow registers. These are
// copied into the active registers only at the end of a frame, so a frame never
// mixes old and new values. Each digit owns a slot of SCAN_DIV cycles. The
// first BLANK_CYC cycles of each slot keep every anode off (anti-ghosting), and
// the remainder of the slot drives the digit.
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 4)
//   BLANK_CYC  blanking cycles at the start of each slot (1 .. SCAN_DIV-1)
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   wr_en       write strobe, one cycle per write
//   wr_sel      0 = digit data, 1 = masks, 2/3 = ignored
//   wr_data     sel 0: nibble i -> digit i; sel 1: [7:0] enable, [15:8] dp
//   pending     shadow holds data not yet committed
//   frame_done  one-cycle pulse in the first cycle of each new frame
//   an          anode enables, active-low, an[i] = digit i
//   seg         segments a..g on seg[0]..seg[6], active-low
//   dp          decimal point, active-low
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PscW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PscW-1:0] PscLast  = PscW'(SCAN_DIV - 1);
  localparam logic [PscW-1:0] BlankEnd = PscW'(BLANK_CYC);

  typedef enum logic [0:0] {
    StBlank,
    StDrive
  } phase_e;

  // Shadow (CPU-written) and active (displayed) copies.
  logic [31:0] shd_data_q, shd_data_d;
  logic [7:0]  shd_en_q,   shd_en_d;
  logic [7:0]  shd_dp_q,   shd_dp_d;
  logic [31:0] act_data_q, act_data_d;
  logic [7:0]  act_en_q,   act_en_d;
  logic [7:0]  act_dp_q,   act_dp_d;
  logic        pend_q,     pend_d;

  // Scan sequencing.
  logic [PscW-1:0] psc_q, psc_d;
  logic [2:0]      dig_q, dig_d;
  phase_e          phase_q, phase_d;
  logic            psc_wrap;
  logic            commit;

  // Registered pin drivers.
  logic       fd_q,  fd_d;
  logic [7:0] an_q,  an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q,  dp_d;

  logic       wr_data_hit;
  logic       wr_mask_hit;
  logic       lit;
  logic [3:0] nibble;

  function automatic logic [6:0] hex7(input logic [3:0] val);
    logic [6:0] s;
    s = 7'h7F;
    unique case (val)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot prescaler, digit index and the commit point at the last cycle of digit 7.
  always_comb begin
    psc_wrap = (psc_q == PscLast);
    psc_d    = psc_wrap ? '0 : psc_q + PscW'(1);
    dig_d    = psc_wrap ? dig_q + 3'd1 : dig_q;
    commit   = psc_wrap && (dig_q == 3'd7);
  end

  // Phase FSM: tracks the psc value that will be current next cycle, so
  // phase_q always matches psc_q.
  always_comb begin
    phase_d = StDrive;
    if (psc_d < BlankEnd) begin
      phase_d = StBlank;
    end
  end

  // Shadow writes and commit. The commit copies the shadow as it was before
  // any same-cycle write, and a same-cycle write keeps pending set so the new
  // value goes out with the following frame.
  always_comb begin
    wr_data_hit = wr_en && (wr_sel == 2'd0);
    wr_mask_hit = wr_en && (wr_sel == 2'd1);

    shd_data_d = shd_data_q;
    shd_en_d   = shd_en_q;
    shd_dp_d   = shd_dp_q;
    act_data_d = act_data_q;
    act_en_d   = act_en_q;
    act_dp_d   = act_dp_q;
    pend_d     = pend_q;

    if (commit && pend_q) begin
      act_data_d = shd_data_q;
      act_en_d   = shd_en_q;
      act_dp_d   = shd_dp_q;
      pend_d     = 1'b0;
    end

    if (wr_data_hit) begin
      shd_data_d = wr_data;
      pend_d     = 1'b1;
    end
    if (wr_mask_hit) begin
      shd_en_d = wr_data[7:0];
      shd_dp_d = wr_data[15:8];
      pend_d   = 1'b1;
    end
  end

  // Pin values for the current slot state, registered below. A disabled digit
  // still consumes its slot so brightness does not depend on the mask.
  always_comb begin
    nibble = act_data_q[{dig_q, 2'b00} +: 4];
    lit    = (phase_q == StDrive) && act_en_q[dig_q];
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    fd_d   = commit;
    if (lit) begin
      an_d  = ~(8'h01 << dig_q);
      seg_d = hex7(nibble);
      dp_d  = ~act_dp_q[dig_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_data_q <= '0;
      shd_en_q   <= 8'hFF;
      shd_dp_q   <= 8'h00;
      act_data_q <= '0;
      act_en_q   <= 8'hFF;
      act_dp_q   <= 8'h00;
      pend_q     <= 1'b0;
      psc_q      <= '0;
      dig_q      <= '0;
      phase_q    <= StBlank;
      fd_q       <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      shd_data_q <= shd_data_d;
      shd_en_q   <= shd_en_d;
      shd_dp_q   <= shd_dp_d;
      act_data_q <= act_data_d;
      act_en_q   <= act_en_d;
      act_dp_q   <= act_dp_d;
      pend_q     <= pend_d;
      psc_q      <= psc_d;
      dig_q      <= dig_d;
      phase_q    <= phase_d;
      fd_q       <= fd_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign pending    = pend_q;
  assign frame_done = fd_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule
